aes_key_inv_sched: RTL and testbench



---
 rtl/aes_key_inv_sched_if.sv | 26 ++
 rtl/aes_key_inv_sched.sv | 121 ++++++++++++
 tb/tb_aes_key_inv_sched.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_inv_sched_if.sv
// Key-stream bundle between the inverse key scheduler, its controller/consumer
// and the shared external S-box array.
interface aes_key_inv_sched_if;
    logic         start;
    logic [127:0] last_key;
    logic         ready;
    logic [127:0] key_out;
    logic         key_valid;
    logic         key_ready;
    logic [3:0]   round_o;
    logic         done;
    logic [31:0]  sub_word_o;
    logic [31:0]  sub_word_i;

    // Scheduler side: produces the round-key stream and the S-box request.
    modport master (
        input  start, last_key, key_ready, sub_word_i,
        output ready, key_out, key_valid, round_o, done, sub_word_o
    );

    // Controller / consumer / S-box side.
    modport slave (
        output start, last_key, key_ready, sub_word_i,
        input  ready, key_out, key_valid, round_o, done, sub_word_o
    );
endinterface

// File: rtl/aes_key_inv_sched.sv
// Iterative AES-128 inverse key scheduler. Loads the last round key and steps
// backwards one round key per accepted handshake down to the cipher key.
// SubWord is supplied combinationally by an external shared S-box.
module aes_key_inv_sched #(
    parameter int ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_key_inv_sched_if.master   bus
);
    localparam logic [3:0] LP_ROUNDS = 4'(ROUNDS);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic         r_done;

    logic         w_load;
    logic         w_step;
    logic         w_finish;
    logic [31:0]  w_v0, w_v1, w_v2, w_v3;
    logic [31:0]  w_x;
    logic [127:0] w_key_prev;

    // Round constant of the forward expansion step that produced round i+1.
    function automatic logic [31:0] rcon(input logic [3:0] i);
        logic [7:0] rc;
        case (i)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return {rc, 24'h0};
    endfunction

    assign w_v0 = r_key[127:96];
    assign w_v1 = r_key[95:64];
    assign w_v2 = r_key[63:32];
    assign w_v3 = r_key[31:0];

    // v2^v3 is word 3 of the previous round key; its rotation feeds the S-box.
    // Driven from registered state only, so it holds while stalled.
    assign w_x            = w_v2 ^ w_v3;
    assign bus.sub_word_o = {w_x[23:0], w_x[31:24]};

    assign w_key_prev = {w_v0 ^ bus.sub_word_i ^ rcon(r_round - 4'd1),
                         w_v1 ^ w_v0,
                         w_v2 ^ w_v1,
                         w_v3 ^ w_v2};

    assign bus.key_out   = r_key;
    assign bus.round_o   = r_round;
    assign bus.key_valid = (r_state == S_EMIT);
    assign bus.ready     = (r_state == S_IDLE);
    assign bus.done      = r_done;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: load on start, step on handshake, finish after round 0.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_EMIT;
                    w_load      = 1'b1;
                end
            end
            S_EMIT: begin
                if (bus.key_ready) begin
                    if (r_round != 4'd0) begin
                        w_step = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_finish    = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Key register, round counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key   <= '0;
            r_round <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_key   <= bus.last_key;
                r_round <= LP_ROUNDS;
            end else if (w_step) begin
                r_key   <= w_key_prev;
                r_round <= r_round - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_aes_key_inv_sched.sv
// Scoreboard bench for the AES-128 inverse key scheduler: stimulus pushes the
// expected reverse key stream, a negedge monitor pops on every handshake.
module tb_aes_key_inv_sched;
    logic clk = 1'b0;
    logic rst;

    aes_key_inv_sched_if bus();

    aes_key_inv_sched #(.ROUNDS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] rk [0:10];
    logic [131:0] exp_q [$];

    localparam logic [127:0] A1_CK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] A1_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] A1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;

    // External S-box model.
    assign bus.sub_word_i = {sbox_tab[bus.sub_word_o[31:24]], sbox_tab[bus.sub_word_o[23:16]],
                             sbox_tab[bus.sub_word_o[15:8]],  sbox_tab[bus.sub_word_o[7:0]]};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] rotw(input logic [31:0] x);
        return {x[23:0], x[31:24]};
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Forward FIPS-197 key expansion into rk[0..10].
    task automatic expand(input logic [127:0] ck);
        logic [31:0] wk [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        wk[0] = ck[127:96]; wk[1] = ck[95:64]; wk[2] = ck[63:32]; wk[3] = ck[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = wk[i-1];
            if (i % 4 == 0) begin
                t  = subw(rotw(t)) ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            wk[i] = wk[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {wk[4*r], wk[4*r+1], wk[4*r+2], wk[4*r+3]};
    endtask

    task automatic push_seq(input logic [127:0] ck);
        expand(ck);
        for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), rk[r]});
    endtask

    task automatic start_key(input logic [127:0] lk);
        chk("ready_before_start", 128'(bus.ready), 128'd1);
        bus.start    = 1'b1;
        bus.last_key = lk;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        logic found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            tick();
            if (bus.done) found = 1'b1;
        end
        chk("done_seen", 128'(found), 128'd1);
    endtask

    // Monitor: compare every accepted key against the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.key_valid && bus.key_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got round %0d key %h expected none", bus.round_o, bus.key_out);
            end else begin
                logic [131:0] e;
                e = exp_q.pop_front();
                chk("sb_key", bus.key_out, e[127:0]);
                chk("sb_round", 128'(bus.round_o), 128'(e[131:128]));
                chk("sb_subword", 128'(bus.sub_word_o), 128'(rotw(e[63:32] ^ e[31:0])));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]   inv;
        logic [127:0] ck;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tab[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        rst = 1'b1; bus.start = 1'b0; bus.key_ready = 1'b1; bus.last_key = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ready", 128'(bus.ready), 128'd1);
        chk("rst_valid", 128'(bus.key_valid), 128'd0);
        chk("rst_key", bus.key_out, 128'd0);
        chk("rst_round", 128'(bus.round_o), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        chk("rst_subword", 128'(bus.sub_word_o), 128'd0);

        // Full walk, FIPS-197 A.1.
        push_seq(A1_CK);
        start_key(A1_R10);
        chk("a1_r10_key", bus.key_out, A1_R10);
        chk("a1_r10_round", 128'(bus.round_o), 128'd10);
        chk("a1_r10_subword", 128'(bus.sub_word_o), 128'h5c006e57);
        tick();
        chk("a1_r9_key", bus.key_out, A1_R9);
        for (int i = 0; i < 8; i++) tick();
        chk("a1_r1_key", bus.key_out, A1_R1);
        chk("a1_r1_round", 128'(bus.round_o), 128'd1);
        tick();
        chk("a1_r0_key", bus.key_out, A1_CK);
        chk("a1_r0_done_low", 128'(bus.done), 128'd0);
        tick();
        chk("a1_done_at_12", 128'(bus.done), 128'd1);
        chk("a1_ready_at_12", 128'(bus.ready), 128'd1);
        chk("a1_r0_hold", bus.key_out, A1_CK);
        tick();
        chk("a1_done_one_cycle", 128'(bus.done), 128'd0);

        // Backpressure: stall 3 cycles on round 7.
        ck = {$urandom, $urandom, $urandom, $urandom};
        push_seq(ck);
        start_key(rk[10]);
        tick(); tick(); tick();
        chk("bp_round7", 128'(bus.round_o), 128'd7);
        bus.key_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            chk("bp_hold_key", bus.key_out, rk[7]);
            chk("bp_hold_round", 128'(bus.round_o), 128'd7);
            chk("bp_hold_subword", 128'(bus.sub_word_o), 128'(rotw(rk[7][63:32] ^ rk[7][31:0])));
        end
        tick();
        bus.key_ready = 1'b1;
        chk("bp_resume_round", 128'(bus.round_o), 128'd7);
        for (int i = 0; i < 7; i++) tick();
        chk("bp_no_early_done", 128'(bus.done), 128'd0);
        tick();
        chk("bp_done_late_by_3", 128'(bus.done), 128'd1);

        // start ignored while emitting.
        ck = {$urandom, $urandom, $urandom, $urandom};
        push_seq(ck);
        start_key(rk[10]);
        for (int i = 0; i < 5; i++) tick();
        chk("ign_round5", 128'(bus.round_o), 128'd5);
        bus.start = 1'b1;
        bus.last_key = ~rk[10];
        tick();
        bus.start = 1'b0;
        chk("ign_round4", 128'(bus.round_o), 128'd4);
        chk("ign_busy", 128'(bus.ready), 128'd0);
        wait_done(20);

        // Reset mid-sequence at round 4.
        push_seq(A1_CK);
        start_key(A1_R10);
        for (int i = 0; i < 6; i++) tick();
        chk("mr_round4", 128'(bus.round_o), 128'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("mr_valid", 128'(bus.key_valid), 128'd0);
        chk("mr_ready", 128'(bus.ready), 128'd1);
        chk("mr_key", bus.key_out, 128'd0);
        chk("mr_round", 128'(bus.round_o), 128'd0);
        chk("mr_done", 128'(bus.done), 128'd0);
        tick();
        chk("mr_no_done", 128'(bus.done), 128'd0);
        push_seq(A1_CK);
        start_key(A1_R10);
        chk("mr_restart_key", bus.key_out, A1_R10);
        chk("mr_restart_round", 128'(bus.round_o), 128'd10);
        wait_done(20);

        // Back-to-back: new start in the done cycle.
        ck = {$urandom, $urandom, $urandom, $urandom};
        push_seq(ck);
        start_key(rk[10]);
        chk("b2b_valid", 128'(bus.key_valid), 128'd1);
        chk("b2b_round", 128'(bus.round_o), 128'd10);
        chk("b2b_key", bus.key_out, rk[10]);
        wait_done(20);

        // Random keys with random consumer stalls.
        for (int n = 0; n < 100; n++) begin
            logic found;
            ck = {$urandom, $urandom, $urandom, $urandom};
            push_seq(ck);
            start_key(rk[10]);
            found = 1'b0;
            for (int i = 0; i < 80 && !found; i++) begin
                bus.key_ready = ($urandom_range(0, 3) != 0);
                tick();
                if (bus.done) found = 1'b1;
            end
            bus.key_ready = 1'b1;
            chk("rnd_done_seen", 128'(found), 128'd1);
        end

        tick(); tick();
        chk("sb_drained", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
